spi_flash_writer: RTL and testbench

- Single-SPI (mode 0) erase/program engine for the on-board SPI flash; write-direction counterpart of the dual-SPI flash reader.
- Runs one 4 KB sector erase (0x20) or one page program (0x02, 1..256 bytes) per command.
- Each command is preceded by WREN (0x06) and completed by polling RDSR (0x05) until WIP=0.
- Sits beside the reader on the same flash pins; top-level muxing gives it ownership while busy=1. Program data is fed byte-wise from the UART receive path.

---
 rtl/spi_flash_writer_pkg.sv | 22 ++
 rtl/spi_byte_shifter.sv | 71 +++++++
 rtl/spi_flash_writer.sv | 176 +++++++++++++++++
 tb/tb_spi_flash_writer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_writer_pkg.sv
// Shared definitions for the SPI flash writer: flash opcodes, page size and control state encoding.
package spi_flash_writer_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam logic [9:0] PAGE_SIZE = 10'd256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_GAP1,
        ST_CMD,
        ST_DATA,
        ST_GAP2,
        ST_POLL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: clock divider plus one 8-bit full-duplex shifter, MSB first.
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte
);

    logic       active;
    logic       sclk_q;
    logic       miso_q;
    logic       done_q;
    logic [7:0] half_cnt;
    logic [5:0] bit_cnt;
    logic [7:0] sh;

    // miso is captured as sclk rises and shifted in on the falling edge, so the
    // shared shifter (and therefore mosi) only moves while sclk is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active   <= 1'b0;
            sclk_q   <= 1'b0;
            miso_q   <= 1'b0;
            done_q   <= 1'b0;
            half_cnt <= 8'd0;
            bit_cnt  <= 6'd0;
            sh       <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (!active) begin
                if (start) begin
                    active   <= 1'b1;
                    sh       <= tx_byte;
                    half_cnt <= 8'd0;
                    bit_cnt  <= 6'd0;
                end
            end else if (half_cnt == 8'(CLK_DIV - 1)) begin
                half_cnt <= 8'd0;
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                    miso_q <= miso;
                end else begin
                    sclk_q  <= 1'b0;
                    sh      <= {sh[6:0], miso_q};
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == 6'd7) begin
                        active <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            end else begin
                half_cnt <= half_cnt + 8'd1;
            end
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = active & sh[7];
    assign busy    = active;
    assign done    = done_q;
    assign rx_byte = sh;

endmodule

// File: rtl/spi_flash_writer.sv
// SPI flash erase/program engine: WREN, then one sector erase or page program, then RDSR polling until WIP clears.
module spi_flash_writer
    import spi_flash_writer_pkg::*;
#(
    parameter int          CLK_DIV  = 2,
    parameter int          CS_GAP   = 4,
    parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_start,
    input  logic        cmd_erase,
    input  logic [23:0] cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  status,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    input  logic        miso,
    output state_t      dbg_state
);

    state_t      state, state_nx;
    logic [23:0] addr_q;
    logic [8:0]  len_q;
    logic        erase_q;
    logic [8:0]  byte_cnt;
    logic [7:0]  gap_cnt;
    logic [23:0] poll_cnt;
    logic [7:0]  status_q;
    logic        err_q;

    logic        sh_start, sh_busy, sh_done;
    logic [7:0]  sh_tx, sh_rx;
    logic        cmd_ok, byte_idle, gap_end, last_data, stat_byte, poll_ready, poll_timeout;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk     (clk),
        .rstn    (rstn),
        .start   (sh_start),
        .tx_byte (sh_tx),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .busy    (sh_busy),
        .done    (sh_done),
        .rx_byte (sh_rx)
    );

    // A program must stay inside one 256-byte page; erase ignores length.
    assign cmd_ok = cmd_erase ||
                    ((cmd_len != 9'd0) && ({1'b0, cmd_len} <= PAGE_SIZE) &&
                     (({2'b00, cmd_addr[7:0]} + {1'b0, cmd_len}) <= PAGE_SIZE));

    assign byte_idle    = !sh_busy && !sh_done;
    assign gap_end      = (gap_cnt == 8'(CS_GAP - 1));
    assign last_data    = ((byte_cnt + 9'd1) == len_q);
    assign stat_byte    = (state == ST_POLL) && sh_done && (byte_cnt != 9'd0);
    assign poll_ready   = stat_byte && !sh_rx[0];
    assign poll_timeout = stat_byte && sh_rx[0] && (poll_cnt >= (POLL_MAX - 24'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (cmd_start && cmd_ok) state_nx = ST_WREN;
            ST_WREN: if (sh_done) state_nx = ST_GAP1;
            ST_GAP1: if (gap_end) state_nx = ST_CMD;
            ST_CMD:  if (sh_done && byte_cnt == 9'd3) state_nx = erase_q ? ST_GAP2 : ST_DATA;
            ST_DATA: if (sh_done && last_data) state_nx = ST_GAP2;
            ST_GAP2: if (gap_end) state_nx = ST_POLL;
            ST_POLL: begin
                if (poll_ready)        state_nx = ST_DONE;
                else if (poll_timeout) state_nx = ST_IDLE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // wr_data is consumed on a clock where wr_valid && wr_ready; wr_ready is only
    // offered at a DATA byte boundary with the shifter idle, so holding wr_valid low
    // just parks the bus with sclk low and cs asserted.
    always_comb begin
        cs       = 1'b1;
        busy     = 1'b1;
        done     = 1'b0;
        wr_ready = 1'b0;
        sh_start = 1'b0;
        sh_tx    = 8'h00;
        case (state)
            ST_IDLE: busy = 1'b0;
            ST_WREN: begin
                cs       = 1'b0;
                sh_tx    = OP_WREN;
                sh_start = byte_idle && (byte_cnt == 9'd0);
            end
            ST_CMD: begin
                cs       = 1'b0;
                sh_start = byte_idle && (byte_cnt < 9'd4);
                case (byte_cnt[1:0])
                    2'd0:    sh_tx = erase_q ? OP_SE : OP_PP;
                    2'd1:    sh_tx = addr_q[23:16];
                    2'd2:    sh_tx = addr_q[15:8];
                    default: sh_tx = addr_q[7:0];
                endcase
            end
            ST_DATA: begin
                cs       = 1'b0;
                wr_ready = byte_idle && (byte_cnt < len_q);
                sh_tx    = wr_data;
                sh_start = wr_ready && wr_valid;
            end
            ST_POLL: begin
                cs       = 1'b0;
                sh_tx    = (byte_cnt == 9'd0) ? OP_RDSR : 8'h00;
                sh_start = byte_idle;
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= 24'd0;
            len_q    <= 9'd0;
            erase_q  <= 1'b0;
            byte_cnt <= 9'd0;
            gap_cnt  <= 8'd0;
            poll_cnt <= 24'd0;
            status_q <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_nx != state) begin
                byte_cnt <= 9'd0;
                gap_cnt  <= 8'd0;
                poll_cnt <= 24'd0;
            end else begin
                if (sh_done) byte_cnt <= (state == ST_POLL) ? 9'd1 : byte_cnt + 9'd1;
                if (state == ST_GAP1 || state == ST_GAP2) gap_cnt <= gap_cnt + 8'd1;
                if (stat_byte) poll_cnt <= poll_cnt + 24'd1;
            end
            if (stat_byte) status_q <= sh_rx;
            if (poll_timeout) err_q <= 1'b1;
            if (state == ST_IDLE && cmd_start) begin
                if (cmd_ok) begin
                    addr_q  <= cmd_erase ? {cmd_addr[23:12], 12'h000} : cmd_addr;
                    len_q   <= cmd_len;
                    erase_q <= cmd_erase;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign status    = status_q;
    assign err       = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_spi_flash_writer.sv
// Directed bench for spi_flash_writer with a behavioural SPI flash model and programmable WIP duration.
module tb_spi_flash_writer;
    import spi_flash_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_erase = 1'b0;
    logic [23:0] cmd_addr = 24'd0;
    logic [8:0]  cmd_len = 9'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready, busy, done, err, sclk, cs, mosi, miso;
    logic [7:0]  status;
    state_t      dbg_state;

    int n_vec = 0;
    int n_err = 0;

    spi_flash_writer #(.CLK_DIV(2), .CS_GAP(4), .POLL_MAX(24'd16)) dut (
        .clk(clk), .rstn(rstn), .cmd_start(cmd_start), .cmd_erase(cmd_erase),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .busy(busy), .done(done), .err(err), .status(status),
        .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- flash model ----------------
    logic       m_cs_d = 1'b1, m_sclk_d = 1'b0;
    logic [7:0] m_rx = 8'h00, m_tx = 8'h00, m_first = 8'h00;
    int         m_bit = 0, m_nbytes = 0, m_sidx = 0, stat_reads = 0;
    int         wip_reads = 0;
    bit         wip_forever = 1'b0;
    logic [7:0] got_q[$];

    assign miso = m_tx[7];

    always @(negedge clk) begin
        if (m_cs_d && !cs) begin
            m_bit = 0; m_nbytes = 0; m_sidx = 0; m_tx = 8'h00;
        end
        if (!cs && !m_sclk_d && sclk) begin
            m_rx = {m_rx[6:0], mosi};
            m_bit++;
            if (m_bit == 8) begin
                got_q.push_back(m_rx);
                if (m_nbytes == 0) m_first = m_rx;
                else if (m_first == OP_RDSR) stat_reads++;
                m_nbytes++;
                m_bit = 0;
            end
        end
        if (!cs && m_sclk_d && !sclk) begin
            if (m_bit == 0 && m_nbytes >= 1 && m_first == OP_RDSR) begin
                m_tx = (wip_forever || m_sidx < wip_reads) ? 8'h03 : 8'h00;
                m_sidx++;
            end else begin
                m_tx = {m_tx[6:0], 1'b0};
            end
        end
        m_cs_d = cs;
        m_sclk_d = sclk;
    end

    // ---------------- monitors ----------------
    int done_cnt = 0, err_cnt = 0, done_busy = 0, cs_low = 0, gap_run = 0, min_gap = 1000;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (busy) done_busy++;
        end
        if (err) err_cnt++;
        if (!cs) begin
            cs_low++;
            if (gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
            gap_run = 0;
        end else if (busy) begin
            gap_run++;
        end else begin
            gap_run = 0;
        end
    end

    // ---------------- scoreboard / drivers ----------------
    logic [7:0] exp_q[$];
    logic [7:0] pdata [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_len"}, got_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (base + k < got_q.size()) check(tag, got_q[base + k], exp_q[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic erase, input logic [23:0] a, input logic [8:0] n);
        cmd_erase = erase; cmd_addr = a; cmd_len = n; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        bit ended = 1'b0;
        for (int g = 0; g < 6000 && !ended; g++) begin
            @(negedge clk);
            if (done || err) ended = 1'b1;
        end
        check({tag, "_ended"}, ended, 1'b1);
    endtask

    task automatic run_prog(input logic [23:0] a, input logic [8:0] n, input int stall_cyc,
                            input bit abort, output int hs, output int st_seen, output int st_bad);
        int  i = 0, stall_left = stall_cyc, abort_wait = 0;
        bit  ended = 1'b0, quit = 1'b0;
        hs = 0; st_seen = 0; st_bad = 0;
        wr_valid = 1'b1; wr_data = pdata[0];
        issue(1'b0, a, n);
        for (int g = 0; g < 6000 && !quit; g++) begin
            @(negedge clk);
            if (done || err) begin
                ended = 1'b1; quit = 1'b1;
            end else begin
                if (wr_valid && wr_ready) begin hs++; i++; end
                if (!wr_valid && wr_ready && i == 2 && stall_left > 0) begin
                    st_seen++;
                    if (sclk !== 1'b0 || cs !== 1'b0) st_bad++;
                    stall_left--;
                end
                if (abort && i == 2) begin
                    abort_wait++;
                    if (abort_wait == 10) quit = 1'b1;
                end
                if (!quit) begin
                    tick();
                    wr_data  = (i < 4) ? pdata[i] : 8'h00;
                    wr_valid = (i < int'(n)) && !(i == 2 && stall_left > 0);
                end
            end
        end
        wr_valid = 1'b0;
        if (!abort) check("prog_ended", ended, 1'b1);
    endtask

    initial begin
        int base, sr0, d0, e0, c0, hs, st_seen, st_bad;

        // reset values while rstn is held low
        #3;
        check("rst_cs", cs, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_status", status, 8'h00);
        check("rst_state", dbg_state, ST_IDLE);
        tick(); rstn = 1'b1; tick(); tick();

        // sector erase, WIP high for three status reads
        wip_reads = 3;
        exp_q = '{8'h06, 8'h20, 8'h01, 8'h20, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        base = got_q.size(); sr0 = stat_reads; d0 = done_cnt;
        issue(1'b1, 24'h012345, 9'd0);
        check("erase_busy_on", busy, 1'b1);
        wait_end("erase");
        check("erase_done", done, 1'b1);
        check("erase_busy_off", busy, 1'b0);
        check("erase_status", status, 8'h00);
        tick();
        check("erase_done_cnt", done_cnt - d0, 1);
        check("erase_reads", stat_reads - sr0, 4);
        check_stream("erase_byte", base);

        // page program, wr_valid always high
        wip_reads = 0;
        exp_q = '{8'h06, 8'h02, 8'h40, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h05, 8'h00};
        base = got_q.size(); d0 = done_cnt;
        run_prog(24'h400010, 9'd4, 0, 1'b0, hs, st_seen, st_bad);
        check("prog_busy_off", busy, 1'b0);
        tick();
        check("prog_hs", hs, 4);
        check("prog_done_cnt", done_cnt - d0, 1);
        check_stream("prog_byte", base);

        // same program with a 20-clock stall before the third byte
        base = got_q.size(); d0 = done_cnt;
        run_prog(24'h400010, 9'd4, 20, 1'b0, hs, st_seen, st_bad);
        tick();
        check("stall_hs", hs, 4);
        check("stall_cycles", st_seen, 20);
        check("stall_bus_moved", st_bad, 0);
        check("stall_done_cnt", done_cnt - d0, 1);
        check_stream("stall_byte", base);

        // rejected programs: len 0, len 257, page crossing
        c0 = cs_low; d0 = done_cnt; e0 = err_cnt;
        issue(1'b0, 24'h400000, 9'd0);
        check("rej0_err", err, 1'b1);
        check("rej0_busy", busy, 1'b0);
        tick();
        check("rej0_err_end", err, 1'b0);
        issue(1'b0, 24'h400000, 9'd257);
        check("rej257_err", err, 1'b1);
        check("rej257_busy", busy, 1'b0);
        tick();
        issue(1'b0, 24'h4000F0, 9'd32);
        check("rejcross_err", err, 1'b1);
        check("rejcross_busy", busy, 1'b0);
        tick(); tick();
        check("rej_err_cnt", err_cnt - e0, 3);
        check("rej_cs_low", cs_low - c0, 0);
        check("rej_done_cnt", done_cnt - d0, 0);

        // WIP stuck high: poll gives up after 16 status bytes
        wip_forever = 1'b1;
        exp_q = '{8'h06, 8'h20, 8'h00, 8'h00, 8'h00, 8'h05};
        base = got_q.size(); sr0 = stat_reads; d0 = done_cnt;
        issue(1'b1, 24'h000000, 9'd0);
        wait_end("tmo");
        check("tmo_err", err, 1'b1);
        check("tmo_busy", busy, 1'b0);
        check("tmo_cs", cs, 1'b1);
        check("tmo_status", status, 8'h03);
        tick();
        check("tmo_err_end", err, 1'b0);
        check("tmo_reads", stat_reads - sr0, 16);
        check("tmo_done_cnt", done_cnt - d0, 0);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'h00);
        check_stream("tmo_byte", base);
        wip_forever = 1'b0;

        // reset asserted while the second data byte is shifting
        run_prog(24'h400010, 9'd4, 0, 1'b1, hs, st_seen, st_bad);
        check("abort_hs", hs, 2);
        check("abort_cs_before", cs, 1'b0);
        tick();
        rstn = 1'b0;
        #1;
        check("abort_cs", cs, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_status", status, 8'h00);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // erase after reset release completes normally, addr[11:0] masked
        wip_reads = 1;
        exp_q = '{8'h06, 8'h20, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
        base = got_q.size(); d0 = done_cnt;
        issue(1'b1, 24'h000FFF, 9'd0);
        wait_end("post");
        check("post_done", done, 1'b1);
        tick();
        check("post_done_cnt", done_cnt - d0, 1);
        check_stream("post_byte", base);

        check("cs_gap_ok", (min_gap >= 4), 1'b1);
        check("done_busy_overlap", done_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
